// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the SRAM bridge-bus arbiter.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RECOVER
    } state_t;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Replicated across the data width for read data returned on a timeout.
    localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/sram_bus_arbiter_rr_picker.sv
// Combinational request picker: round-robin from a base index, or lowest index first.
module rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    input  logic             mode,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam int unsigned SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = SW'(i);
            if (!mode) begin
                sum = sum + {1'b0, base};
                if (sum >= SW'(N)) begin
                    sum = sum - SW'(N);
                end
            end
            cand = sum[IDX_W-1:0];
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// N-master arbiter in front of one SRAM controller bridge port, with ack timeout.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_W         = 19,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned BE_W           = DATA_W / 8,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_bus_enable,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byte_enable,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
    output logic [NUM_MASTERS-1:0]        m_acknowledge,
    output logic [NUM_MASTERS*DATA_W-1:0] m_read_data,
    output logic [NUM_MASTERS-1:0]        m_error,
    output logic [ADDR_W-1:0]             s_address,
    output logic [BE_W-1:0]               s_byte_enable,
    output logic                          s_rw,
    output logic [DATA_W-1:0]             s_write_data,
    output logic                          s_bus_enable,
    input  logic                          s_acknowledge,
    input  logic [DATA_W-1:0]             s_read_data,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_FIRE = CNT_W'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       last_grant, start_idx, pick_idx;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic                   pick_valid, do_grant, do_done, timed_out;

    assign start_idx = (last_grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : last_grant + 1'b1;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (m_bus_enable),
        .base   (start_idx),
        .mode   (ARB_MODE == ARB_FIXED),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter is 0 on the first BUSY cycle; firing at TIMEOUT_CYCLES places the
    // error ack TIMEOUT_CYCLES+1 cycles after s_bus_enable rises. Ack takes precedence.
    always_comb begin
        state_d   = state_q;
        do_grant  = 1'b0;
        do_done   = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    do_grant = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (s_acknowledge) begin
                    do_done = 1'b1;
                    state_d = RECOVER;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TMO_FIRE)) begin
                    do_done   = 1'b1;
                    timed_out = 1'b1;
                    state_d   = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q         <= '0;
            last_grant    <= IDX_W'(NUM_MASTERS - 1);
            grant         <= '0;
            s_bus_enable  <= 1'b0;
            s_address     <= '0;
            s_byte_enable <= '0;
            s_rw          <= 1'b0;
            s_write_data  <= '0;
            m_acknowledge <= '0;
            m_error       <= '0;
            m_read_data   <= '0;
        end else begin
            m_acknowledge <= '0;
            m_error       <= '0;

            if (do_grant) begin
                s_address     <= m_address[pick_idx*ADDR_W +: ADDR_W];
                s_byte_enable <= m_byte_enable[pick_idx*BE_W +: BE_W];
                s_rw          <= m_rw[pick_idx];
                s_write_data  <= m_write_data[pick_idx*DATA_W +: DATA_W];
                s_bus_enable  <= 1'b1;
                grant         <= pick_onehot;
                cnt_q         <= '0;
                if (ARB_MODE == ARB_RR) begin
                    last_grant <= pick_idx;
                end
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (do_done) begin
                s_bus_enable  <= 1'b0;
                grant         <= '0;
                m_acknowledge <= grant;
                m_error       <= timed_out ? grant : '0;
                for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                    if (grant[i]) begin
                        m_read_data[i*DATA_W +: DATA_W] <= timed_out ? {DATA_W{TIMEOUT_FILL}} : s_read_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: round-robin/timeout instance plus a fixed-priority instance.
module tb_sram_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int BW = 2;

    typedef struct {
        int          master;
        logic [DW-1:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb_fp[$];
    exp_t mon_e;
    exp_t fp_e;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   rsp_lat = 1;
    int   be_cnt = 0;
    logic rsp_on = 1'b0;
    logic stray = 1'b0;

    logic clk = 1'b0;
    logic rst_n;

    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_bus_enable;
    logic [N*BW-1:0] m_byte_enable;
    logic [N-1:0]    m_rw;
    logic [N*DW-1:0] m_write_data;

    logic [N-1:0]    m_acknowledge, m_error, grant;
    logic [N*DW-1:0] m_read_data;
    logic [AW-1:0]   s_address;
    logic [BW-1:0]   s_byte_enable;
    logic            s_rw, s_bus_enable, s_acknowledge;
    logic [DW-1:0]   s_write_data, s_read_data;

    logic [N-1:0]    fp_bus_enable, fp_ack, fp_err, fp_grant;
    logic [N*DW-1:0] fp_rdata;
    logic [AW-1:0]   fp_s_address;
    logic [BW-1:0]   fp_s_byte_enable;
    logic            fp_s_rw, fp_s_bus_enable, fp_s_ack;
    logic [DW-1:0]   fp_s_write_data, fp_s_rdata;

    sram_bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .ARB_MODE       (0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .m_address     (m_address),
        .m_bus_enable  (m_bus_enable),
        .m_byte_enable (m_byte_enable),
        .m_rw          (m_rw),
        .m_write_data  (m_write_data),
        .m_acknowledge (m_acknowledge),
        .m_read_data   (m_read_data),
        .m_error       (m_error),
        .s_address     (s_address),
        .s_byte_enable (s_byte_enable),
        .s_rw          (s_rw),
        .s_write_data  (s_write_data),
        .s_bus_enable  (s_bus_enable),
        .s_acknowledge (s_acknowledge),
        .s_read_data   (s_read_data),
        .grant         (grant)
    );

    sram_bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .ARB_MODE       (1),
        .TIMEOUT_CYCLES (0)
    ) dut_fp (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .m_address     (m_address),
        .m_bus_enable  (fp_bus_enable),
        .m_byte_enable (m_byte_enable),
        .m_rw          (m_rw),
        .m_write_data  (m_write_data),
        .m_acknowledge (fp_ack),
        .m_read_data   (fp_rdata),
        .m_error       (fp_err),
        .s_address     (fp_s_address),
        .s_byte_enable (fp_s_byte_enable),
        .s_rw          (fp_s_rw),
        .s_write_data  (fp_s_write_data),
        .s_bus_enable  (fp_s_bus_enable),
        .s_acknowledge (fp_s_ack),
        .s_read_data   (fp_s_rdata),
        .grant         (fp_grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hBEFF;
    endfunction

    function automatic exp_t mk(input int m, input logic [DW-1:0] d, input logic e, input int c);
        exp_t x;
        x.master = m;
        x.data   = d;
        x.err    = e;
        x.cyc    = c;
        return x;
    endfunction

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic [BW-1:0] be,
                              input logic rw, input logic [DW-1:0] wd);
        m_address[i*AW +: AW]     = a;
        m_byte_enable[i*BW +: BW] = be;
        m_rw[i]                   = rw;
        m_write_data[i*DW +: DW]  = wd;
    endtask

    task automatic wait_drain(input bit fp, input int budget, input string tag);
        int n = 0;
        while (((fp ? sb_fp.size() : sb.size()) != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_drain"}, 64'(fp ? sb_fp.size() : sb.size()), 64'd0);
    endtask

    // Slave models: ack rsp_lat cycles into the request; data derived from address.
    initial begin
        s_acknowledge = 1'b0;
        s_read_data   = '0;
        forever begin
            @(negedge clk);
            if (s_bus_enable && rsp_on) begin
                be_cnt++;
                s_acknowledge = (be_cnt == rsp_lat) || stray;
            end else begin
                be_cnt = 0;
                s_acknowledge = stray;
            end
            s_read_data = rd_of(s_address);
        end
    end

    initial begin
        fp_s_ack   = 1'b0;
        fp_s_rdata = '0;
        forever begin
            @(negedge clk);
            fp_s_ack   = fp_s_bus_enable && !fp_s_ack;
            fp_s_rdata = rd_of(fp_s_address);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_acknowledge != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 64'(m_acknowledge), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_onehot", 64'(m_acknowledge), 64'(3'b001 << mon_e.master));
                    check("ack_data", 64'(m_read_data[mon_e.master*DW +: DW]), 64'(mon_e.data));
                    check("ack_error", 64'(m_error), mon_e.err ? 64'(3'b001 << mon_e.master) : 64'd0);
                    if (mon_e.cyc >= 0) check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (fp_ack != '0) begin
                if (sb_fp.size() == 0) begin
                    check("fp_unexpected_ack", 64'(fp_ack), 64'd0);
                end else begin
                    fp_e = sb_fp.pop_front();
                    check("fp_ack_onehot", 64'(fp_ack), 64'(3'b001 << fp_e.master));
                    check("fp_ack_data", 64'(fp_rdata[fp_e.master*DW +: DW]), 64'(fp_e.data));
                    check("fp_ack_error", 64'(fp_err), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        m_address     = '0;
        m_bus_enable  = '0;
        m_byte_enable = '0;
        m_rw          = '0;
        m_write_data  = '0;
        fp_bus_enable = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_be", 64'(s_bus_enable), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ack", 64'(m_acknowledge), 64'd0);
        check("rst_s_addr", 64'(s_address), 64'd0);
        check("rst_rdata", 64'(m_read_data), 64'd0);
        check("rst_fp_grant", 64'(fp_grant), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Round-robin with all three masters requesting continuously
        for (int i = 0; i < N; i++) set_master(i, 19'h00100 + AW'(i), 2'b11, 1'b1, 16'h0000);
        for (int k = 0; k < 6; k++) sb.push_back(mk(k % 3, rd_of(19'h00100 + AW'(k % 3)), 1'b0, -1));
        rsp_lat = 1;
        rsp_on = 1'b1;
        m_bus_enable = 3'b111;
        wait_drain(0, 60, "rr");
        m_bus_enable = '0;

        // Single master read, slave acks at cycle 3
        repeat (2) @(negedge clk);
        #1;
        set_master(0, 19'h00010, 2'b11, 1'b1, 16'h0000);
        rsp_lat = 3;
        c0 = cyc;
        sb.push_back(mk(0, 16'hBEEF, 1'b0, c0 + 4));
        m_bus_enable = 3'b001;
        wait_drain(0, 20, "single");
        m_bus_enable = '0;

        // Write with byte enables, fields held until ack
        repeat (2) @(negedge clk);
        #1;
        set_master(1, 19'h7FFFF, 2'b01, 1'b0, 16'h1234);
        rsp_lat = 4;
        c0 = cyc;
        sb.push_back(mk(1, rd_of(19'h7FFFF), 1'b0, c0 + 5));
        m_bus_enable = 3'b010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("wr_s_be", 64'(s_bus_enable), 64'd1);
            check("wr_addr", 64'(s_address), 64'h7FFFF);
            check("wr_be", 64'(s_byte_enable), 64'h1);
            check("wr_rw", 64'(s_rw), 64'd0);
            check("wr_data", 64'(s_write_data), 64'h1234);
            check("wr_grant", 64'(grant), 64'h2);
        end
        wait_drain(0, 20, "write");
        m_bus_enable = '0;

        // Timeout: slave silent, then a late ack that must be ignored
        repeat (2) @(negedge clk);
        #1;
        rsp_on = 1'b0;
        set_master(2, 19'h00222, 2'b11, 1'b1, 16'h0000);
        c0 = cyc;
        sb.push_back(mk(2, 16'hFFFF, 1'b1, c0 + 10));
        m_bus_enable = 3'b100;
        wait_drain(0, 30, "timeout");
        m_bus_enable = '0;
        stray = 1'b1;
        @(negedge clk);
        #1;
        stray = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("stray_s_be", 64'(s_bus_enable), 64'd0);
        check("stray_grant", 64'(grant), 64'd0);

        // Fixed priority: master 1 starves master 2 until it drops
        set_master(1, 19'h00301, 2'b10, 1'b1, 16'h5A5A);
        set_master(2, 19'h00302, 2'b11, 1'b1, 16'h0000);
        for (int k = 0; k < 3; k++) sb_fp.push_back(mk(1, rd_of(19'h00301), 1'b0, -1));
        fp_bus_enable = 3'b110;
        @(negedge clk);
        #1;
        check("fp_grant", 64'(fp_grant), 64'h2);
        check("fp_s_addr", 64'(fp_s_address), 64'h00301);
        check("fp_s_fields", 64'({fp_s_rw, fp_s_byte_enable, fp_s_write_data}), 64'({1'b1, 2'b10, 16'h5A5A}));
        wait_drain(1, 40, "fixed_hi");
        fp_bus_enable = 3'b100;
        sb_fp.push_back(mk(2, rd_of(19'h00302), 1'b0, -1));
        wait_drain(1, 20, "fixed_lo");
        fp_bus_enable = '0;

        // Reset mid-transaction, then master 0 must win first
        repeat (2) @(negedge clk);
        #1;
        set_master(0, 19'h00400, 2'b11, 1'b1, 16'h0000);
        set_master(1, 19'h00401, 2'b11, 1'b1, 16'h0000);
        m_bus_enable = 3'b010;
        @(negedge clk);
        #1;
        check("pre_rst_s_be", 64'(s_bus_enable), 64'd1);
        check("pre_rst_grant", 64'(grant), 64'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_be", 64'(s_bus_enable), 64'd0);
        check("mid_rst_grant", 64'(grant), 64'd0);
        m_bus_enable = 3'b111;
        rsp_lat = 1;
        rsp_on = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("mid_rst_ack", 64'(m_acknowledge), 64'd0);
        rst_n = 1'b1;
        sb.push_back(mk(0, rd_of(19'h00400), 1'b0, -1));
        @(negedge clk);
        #1;
        check("post_rst_grant", 64'(grant), 64'h1);
        wait_drain(0, 20, "post_rst");
        m_bus_enable = '0;

        repeat (4) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
